// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// SUB_OVF_EN adds the signed-overflow flag to the bus.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, DIFF = A - B, LSB first through one full-subtractor cell
// with a registered borrow. Define SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             d_c;
  logic             bout_c;
  logic             last_c;

  // Full-subtractor cell on the current LSBs
  assign d_c    = a_sr[0] ^ b_sr[0] ^ bin;
  assign bout_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin);
  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_c)    state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Handshake flags are registered copies of the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      done_q <= (state_next == ST_DONE);
    end
  end

  // a_sr doubles as the result register: difference bits enter at the MSB
  // as minuend bits leave at the LSB, so after WIDTH shifts it holds DIFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      bin      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        bin  <= 1'b0;
        cnt  <= '0;
      end
    end else if (state == ST_RUN) begin
      a_sr <= {d_c, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      bin  <= bout_c;
      cnt  <= cnt + CNT_W'(1);
      if (last_c) begin
        diff_q   <= {d_c, a_sr[WIDTH-1:1]};
        borrow_q <= bout_c;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand sign bits are kept aside since the shift registers consume them;
  // the final serial bit is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
    end else if (state == ST_RUN && last_c) begin
      ovf_q <= (a_msb != b_msb) && (d_c != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
// Checks ovf as well when built with SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain integer arithmetic
  function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'(a) - int'(b);
    if (r < 0) r = r + 256;
    return 8'(r);
  endfunction

  function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) - int'(b)) < 0;
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'($signed(a)) - int'($signed(b));
    return (r > 127) || (r < -128);
  endfunction

  // Starts an op from a negedge in IDLE; returns at the negedge of the done cycle.
  // lat = clock edges from accept to done (-1 on timeout).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                       input bit pulse, output int lat, output logic [7:0] mid_diff);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    mid_diff  = 8'h00;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done === 1'b1) break;
      if (lat == 2 && scramble) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end
      bus.start = (lat == 3 && pulse) ? 1'b1 : 1'b0;
      if (lat == 4) mid_diff = bus.diff;
    end
    if (bus.done !== 1'b1) lat = -1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++;
    if (bus.diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff got=%h exp=00", bus.diff); end
    vectors++;
    if (bus.borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_borrow got=%b exp=0", bus.borrow_out); end
`ifdef SUB_OVF_EN
    vectors++;
    if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h05, 8'h00, 8'h80, 8'hA5};
    logic [7:0] vb [4] = '{8'h03, 8'h01, 8'h01, 8'hA5};
    int lat;
    logic [7:0] mid;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b0, 1'b0, lat, mid);
      vectors++;
      if (lat != int'(WIDTH)) begin miscompares++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WIDTH); end
      vectors++;
      if (bus.diff !== ref_diff(va[i], vb[i])) begin
        miscompares++; $display("FAIL dir%0d_diff got=%h exp=%h", i, bus.diff, ref_diff(va[i], vb[i]));
      end
      vectors++;
      if (bus.borrow_out !== ref_borrow(va[i], vb[i])) begin
        miscompares++; $display("FAIL dir%0d_borrow got=%b exp=%b", i, bus.borrow_out, ref_borrow(va[i], vb[i]));
      end
`ifdef SUB_OVF_EN
      vectors++;
      if (bus.ovf !== ref_ovf(va[i], vb[i])) begin
        miscompares++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, bus.ovf, ref_ovf(va[i], vb[i]));
      end
`endif
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++; $display("FAIL dir%0d_pulse_end done=%b busy=%b exp 0/0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_mid_run_change();
    int lat;
    logic [7:0] mid;
    do_op(8'h05, 8'h03, 1'b0, 1'b0, lat, mid);
    @(negedge clk);
    do_op(8'hA5, 8'hA5, 1'b1, 1'b0, lat, mid);
    vectors++;
    if (mid !== 8'h02) begin miscompares++; $display("FAIL hold_during_run got=%h exp=02", mid); end
    vectors++;
    if (lat != int'(WIDTH)) begin miscompares++; $display("FAIL scramble_latency got=%0d exp=%0d", lat, WIDTH); end
    vectors++;
    if (bus.diff !== 8'h00 || bus.borrow_out !== 1'b0) begin
      miscompares++; $display("FAIL scramble_result got=%h/%b exp=00/0", bus.diff, bus.borrow_out);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [7:0] mid;
    logic [7:0] ra;
    logic [7:0] rb;
    bit extra_done;
    do_op(8'h37, 8'h12, 1'b0, 1'b1, lat, mid);
    vectors++;
    if (lat != int'(WIDTH) || bus.diff !== 8'h25) begin
      miscompares++; $display("FAIL busy_start_op got lat=%0d diff=%h exp lat=%0d diff=25", lat, bus.diff, WIDTH);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_ignored done=%b busy=%b exp 0/0", bus.done, bus.busy);
    end
    // New start in the IDLE cycle right after done
    ra = 8'($urandom);
    rb = 8'($urandom);
    do_op(ra, rb, 1'b0, 1'b0, lat, mid);
    vectors++;
    if (lat != int'(WIDTH)) begin miscompares++; $display("FAIL back_to_back_latency got=%0d exp=%0d", lat, WIDTH); end
    vectors++;
    if (bus.diff !== ref_diff(ra, rb) || bus.borrow_out !== ref_borrow(ra, rb)) begin
      miscompares++; $display("FAIL back_to_back_result got=%h/%b exp=%h/%b", bus.diff, bus.borrow_out,
                              ref_diff(ra, rb), ref_borrow(ra, rb));
    end
    extra_done = 1'b0;
    repeat (WIDTH + 3) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done = 1'b1;
    end
    vectors++;
    if (extra_done) begin miscompares++; $display("FAIL no_queued_op got activity=1 exp=0"); end
  endtask

  task automatic test_abort();
    int lat;
    logic [7:0] mid;
    bit seen;
    do_op(8'h05, 8'h03, 1'b0, 1'b0, lat, mid);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hC3;
    bus.b     = 8'h17;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL abort_flags busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.diff !== 8'h00 || bus.borrow_out !== 1'b0) begin
      miscompares++; $display("FAIL abort_result got=%h/%b exp=00/0", bus.diff, bus.borrow_out);
    end
`ifdef SUB_OVF_EN
    vectors++;
    if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL abort_ovf got=%b exp=0", bus.ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_no_done got done=1 exp=0"); end
    do_op(8'h10, 8'h20, 1'b0, 1'b0, lat, mid);
    vectors++;
    if (lat != int'(WIDTH) || bus.diff !== 8'hF0 || bus.borrow_out !== 1'b1) begin
      miscompares++; $display("FAIL after_abort_op got lat=%0d %h/%b exp lat=%0d F0/1", lat, bus.diff,
                              bus.borrow_out, WIDTH);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] mid;
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = (i % 6 == 0) ? ra : 8'($urandom);
      do_op(ra, rb, 1'b0, 1'b0, lat, mid);
      vectors++;
      if (lat != int'(WIDTH) || bus.diff !== ref_diff(ra, rb) || bus.borrow_out !== ref_borrow(ra, rb)) begin
        miscompares++;
        $display("FAIL rand%0d a=%h b=%h got lat=%0d %h/%b exp lat=%0d %h/%b", i, ra, rb, lat, bus.diff,
                 bus.borrow_out, WIDTH, ref_diff(ra, rb), ref_borrow(ra, rb));
      end
`ifdef SUB_OVF_EN
      vectors++;
      if (bus.ovf !== ref_ovf(ra, rb)) begin
        miscompares++; $display("FAIL rand%0d_ovf a=%h b=%h got=%b exp=%b", i, ra, rb, bus.ovf, ref_ovf(ra, rb));
      end
`endif
      // Gap of 0 starts again in the IDLE cycle right after done
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_run_change();
    test_start_while_busy();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
